// File: rtl/mul_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mul_pipe_pkg
// Description : Shared constants and helper functions for the parametrised
//               pipelined multiplier. Holds the front-end stage layout and the
//               latency function, so the multiplier and its users agree on
//               timing.
//               Optional feature macro: MUL_PIPE_SIGNED_EN (used by the
//               multiplier, not by this package).
// Revision    : 1.0 - initial release
// ============================================================================
package mul_pipe_pkg;

    // Front-end register stages ahead of the adder tree
    localparam int MUL_PIPE_OPERAND_STAGE = 0;  // a, b, is_signed, valid
    localparam int MUL_PIPE_PP_STAGE      = 1;  // W partial products, 2W wide
    localparam int MUL_PIPE_FRONT_STAGES  = 2;

    // Ceiling log2; clog2(1) = 0
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = 1; v < value; v = v << 1) begin
            result++;
        end
        return result;
    endfunction

    // Accept-to-output latency in unstalled clock cycles
    function automatic int mul_pipe_lat(input int w);
        return MUL_PIPE_FRONT_STAGES + clog2(w);
    endfunction

    // Supported operand widths: powers of two from 4 to 64
    function automatic bit mul_pipe_w_ok(input int w);
        return (w >= 4) && (w <= 64) && ((w & (w - 1)) == 0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mul_pipe_add_level.sv
`default_nettype none
// ============================================================================
// Module      : mul_pipe_add_level
// Description : One registered level of the product adder tree. Adds adjacent
//               pairs (2j, 2j+1) of N_IN inputs modulo 2^(2W) and registers the
//               N_IN/2 sums together with a valid bit. The whole level holds
//               while en is low. Sum registers only load on valid data so the
//               last level keeps presenting its previous product during
//               bubbles.
// Ports       : clk, reset      - clock, synchronous active-high reset
//               en              - advance enable (low while the pipe stalls)
//               in_valid/in_data   - previous level valid bit and operands
//               out_valid/out_data - registered valid bit and pairwise sums
// Revision    : 1.0 - initial release
// ============================================================================
module mul_pipe_add_level
    import mul_pipe_pkg::*;
#(
    parameter int N_IN = 2,   // even number of inputs
    parameter int W    = 32   // operand width; data paths are 2W wide
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          en,
    input  logic                          in_valid,
    input  logic [N_IN-1:0][2*W-1:0]      in_data,
    output logic                          out_valid,
    output logic [N_IN/2-1:0][2*W-1:0]    out_data
);

    logic [N_IN/2-1:0][2*W-1:0] w_sum;
    logic [N_IN/2-1:0][2*W-1:0] r_sum;
    logic                       r_valid;

    // Carry out of each 2W-bit add is dropped: the product is taken mod 2^(2W)
    always_comb begin
        w_sum = '0;
        for (int j = 0; j < N_IN / 2; j++) begin
            w_sum[j] = in_data[2*j] + in_data[2*j+1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_sum   <= '0;
        end else if (en) begin
            r_valid <= in_valid;
            if (in_valid) begin
                r_sum <= w_sum;
            end
        end
    end

    assign out_valid = r_valid;
    assign out_data  = r_sum;

endmodule
`default_nettype wire

// File: rtl/mul_pipe_param.sv
`default_nettype none
// ============================================================================
// Module      : mul_pipe_param
// Description : Pipelined W x W -> 2W integer multiplier with valid/ready flow
//               control. Stage 0 registers the operands, stage 1 registers W
//               partial products, then log2(W) registered adder levels reduce
//               them to the product. Latency is mul_pipe_lat(W) = 2 + log2(W)
//               cycles. A stalled output (out_valid && !out_ready) freezes the
//               entire pipe and deasserts in_ready.
//               Macro MUL_PIPE_SIGNED_EN: when defined, is_signed selects a
//               two's-complement multiply per transaction; when undefined,
//               is_signed is ignored and every product is unsigned.
// Ports       : clk, reset          - clock, synchronous active-high reset
//               in_valid, in_ready  - input handshake
//               a, b, is_signed     - operands and per-op signedness
//               out_valid, out_ready - output handshake
//               out                 - 2W-bit product
// Revision    : 1.0 - initial release
// ============================================================================
module mul_pipe_param
    import mul_pipe_pkg::*;
#(
    parameter int W = 32
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    input  logic           is_signed,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] out
);

    localparam int LEVELS = clog2(W);
    localparam int LAT    = mul_pipe_lat(W);

    if (!mul_pipe_w_ok(W) || (LAT != MUL_PIPE_FRONT_STAGES + LEVELS)) begin : g_bad_w
        $error("mul_pipe_param: W must be a power of two between 4 and 64");
    end

    logic w_en;

    // Stage 0: operand registers
    logic [W-1:0] r_a0;
    logic [W-1:0] r_b0;
    logic         r_v0;
    logic         w_signed0;

    // Stage 1: partial products
    logic [2*W-1:0]          w_a_ext;
    logic [W-1:0][2*W-1:0]   w_pp;
    logic [W-1:0][2*W-1:0]   r_pp;
    logic                    r_v1;

    // Whole-pipe stall whenever the product cannot leave
    assign w_en     = !(out_valid && !out_ready);
    assign in_ready = w_en;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_v0 <= 1'b0;
            r_a0 <= '0;
            r_b0 <= '0;
        end else if (w_en) begin
            r_v0 <= in_valid;
            r_a0 <= a;
            r_b0 <= b;
        end
    end

`ifdef MUL_PIPE_SIGNED_EN
    logic r_s0;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s0 <= 1'b0;
        end else if (w_en) begin
            r_s0 <= is_signed;
        end
    end

    assign w_signed0 = r_s0;
`else
    logic w_unused_is_signed;

    assign w_unused_is_signed = is_signed;
    assign w_signed0          = 1'b0;
`endif

    // pp[k] = b[k] ? A_ext << k : 0. In signed mode the MSB of b carries
    // weight -2^(W-1), so that row is negated instead of added.
    always_comb begin
        w_a_ext = {{W{1'b0}}, r_a0};
        w_pp    = '0;
`ifdef MUL_PIPE_SIGNED_EN
        if (w_signed0) begin
            w_a_ext = {{W{r_a0[W-1]}}, r_a0};
        end
`endif
        for (int k = 0; k < W; k++) begin
            w_pp[k] = r_b0[k] ? (w_a_ext << k) : '0;
        end
`ifdef MUL_PIPE_SIGNED_EN
        if (w_signed0 && r_b0[W-1]) begin
            w_pp[W-1] = -(w_a_ext << (W - 1));
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_v1 <= 1'b0;
            r_pp <= '0;
        end else if (w_en) begin
            r_v1 <= r_v0;
            r_pp <= w_pp;
        end
    end

    // Adder tree: level l reduces W >> l values to W >> (l+1)
    for (genvar l = 0; l < LEVELS; l++) begin : g_level
        localparam int N_IN = W >> l;

        logic                          w_v;
        logic [N_IN/2-1:0][2*W-1:0]    w_sum;

        if (l == 0) begin : g_first
            mul_pipe_add_level #(
                .N_IN (N_IN),
                .W    (W)
            ) u_level (
                .clk       (clk),
                .reset     (reset),
                .en        (w_en),
                .in_valid  (r_v1),
                .in_data   (r_pp),
                .out_valid (w_v),
                .out_data  (w_sum)
            );
        end else begin : g_rest
            mul_pipe_add_level #(
                .N_IN (N_IN),
                .W    (W)
            ) u_level (
                .clk       (clk),
                .reset     (reset),
                .en        (w_en),
                .in_valid  (g_level[l-1].w_v),
                .in_data   (g_level[l-1].w_sum),
                .out_valid (w_v),
                .out_data  (w_sum)
            );
        end
    end

    assign out_valid = g_level[LEVELS-1].w_v;
    assign out       = g_level[LEVELS-1].w_sum[0];

endmodule
`default_nettype wire

// File: tb/tb_mul_pipe_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_mul_pipe_param
// Description : Scoreboard bench for mul_pipe_param (W=32 main instance plus a
//               W=8 instance). Stimulus pushes expected products; a monitor
//               pops and compares whenever a product transfers out.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mul_pipe_param;
    import mul_pipe_pkg::*;

    localparam int W    = 32;
    localparam int LAT  = mul_pipe_lat(W);
    localparam int LAT8 = mul_pipe_lat(8);
`ifdef MUL_PIPE_SIGNED_EN
    localparam bit SIGNED_EN = 1'b1;
`else
    localparam bit SIGNED_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid, in_ready, is_signed, out_valid, out_ready;
    logic [31:0]   a, b;
    logic [63:0]   out;
    logic          in_valid8, in_ready8, is_signed8, out_valid8, out_ready8;
    logic [7:0]    a8, b8;
    logic [15:0]   out8;

    int cyc = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mul_pipe_param #(.W(32)) u_dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .is_signed(is_signed), .out_valid(out_valid),
        .out_ready(out_ready), .out(out)
    );

    mul_pipe_param #(.W(8)) u_dut8 (
        .clk(clk), .reset(reset), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .is_signed(is_signed8), .out_valid(out_valid8),
        .out_ready(out_ready8), .out(out8)
    );

    typedef struct {
        logic [63:0] exp;
        int          t_drive;
        int          s_at;
    } item_t;

    item_t       sb[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          stall_cnt = 0;
    int          stall_start = -1;
    int          stall_end = -1;
    bit          prev_stall = 1'b0;
    logic [63:0] prev_out = '0;

    function automatic logic [63:0] ref_mul(input logic [31:0] x, input logic [31:0] y,
                                            input logic s);
        logic [63:0] ex, ey;
        ex = {32'b0, x};
        ey = {32'b0, y};
        if (s && SIGNED_EN) begin
            ex = {{32{x[31]}}, x};
            ey = {{32{y[31]}}, y};
        end
        return ex * ey;
    endfunction

    task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall && out_valid) chk64("held_out", out, prev_out);
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_out: got %h expected no output (cycle %0d)", out, cyc);
                    end else begin
                        item_t it;
                        it = sb.pop_front();
                        chk64("product", out, it.exp);
                        chk_int("latency", cyc, it.t_drive + LAT + (stall_cnt - it.s_at));
                    end
                end
                if (out_valid && !out_ready) begin
                    chk64("in_ready_stall", {63'b0, in_ready}, 64'd0);
                    stall_cnt++;
                    prev_stall = 1'b1;
                    prev_out   = out;
                end else begin
                    prev_stall = 1'b0;
                end
            end
        end
    endtask

    function automatic logic ready_now();
        return !(cyc >= stall_start && cyc < stall_end);
    endfunction

    // Present one op and hold it until the pipe accepts it
    task automatic issue(input logic [31:0] x, input logic [31:0] y, input logic s,
                         input logic [63:0] exp);
        bit done;
        int tries;
        item_t it;
        done  = 1'b0;
        tries = 0;
        while (!done) begin
            @(posedge clk);
            #1;
            out_ready = ready_now();
            in_valid  = 1'b1;
            a         = x;
            b         = y;
            is_signed = s;
            #1;
            if (in_ready) begin
                it.exp     = exp;
                it.t_drive = cyc;
                it.s_at    = stall_cnt;
                sb.push_back(it);
                done = 1'b1;
            end else if (++tries > 50) begin
                n_cmp++;
                n_bad++;
                $display("FAIL accept_timeout: got in_ready=0 expected 1 within 50 cycles");
                done = 1'b1;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            in_valid  = 1'b0;
            out_ready = ready_now();
        end
    endtask

    task automatic drain();
        int waited;
        waited = 0;
        while (sb.size() != 0 && waited < 100) begin
            idle(1);
            waited++;
        end
        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
            sb.delete();
        end
        idle(3);
    endtask

    initial begin
        logic [31:0] rx, ry;
        logic        rs;
        int          t0;

        reset = 1'b1;
        in_valid = 1'b0; a = '0; b = '0; is_signed = 1'b0; out_ready = 1'b1;
        in_valid8 = 1'b0; a8 = '0; b8 = '0; is_signed8 = 1'b0; out_ready8 = 1'b1;
        fork
            monitor();
        join_none

        repeat (3) @(posedge clk);
        #1;
        chk64("reset_out_valid", {63'b0, out_valid}, 64'd0);
        chk64("reset_out", out, 64'd0);
        chk64("reset_in_ready", {63'b0, in_ready}, 64'd1);
        chk64("reset_out_valid8", {63'b0, out_valid8}, 64'd0);
        reset = 1'b0;

        // Single unsigned op
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001);
        drain();

        // Signed directed ops (unsigned results when the signed path is absent)
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1,
              SIGNED_EN ? 64'h0000_0000_0000_0001 : 64'hFFFF_FFFE_0000_0001);
        issue(32'h8000_0000, 32'h0000_0002, 1'b1,
              SIGNED_EN ? 64'hFFFF_FFFF_0000_0000 : 64'h0000_0001_0000_0000);
        issue(32'hFFFF_FFFD, 32'h0000_0007, 1'b1,
              SIGNED_EN ? 64'hFFFF_FFFF_FFFF_FFEB : 64'h0000_0006_FFFF_FFEB);
        issue(32'h0000_0005, 32'h0000_0006, 1'b0, 64'd30);
        drain();

        // Back-to-back mixed stream
        for (int i = 0; i < 20; i++) begin
            rx = $urandom;
            ry = $urandom;
            rs = 1'($urandom_range(0, 1));
            issue(rx, ry, rs, ref_mul(rx, ry, rs));
        end
        drain();

        // Backpressure: out_ready low for 3 cycles mid-stream
        stall_start = cyc + 9;
        stall_end   = stall_start + 3;
        for (int i = 0; i < 10; i++) begin
            rx = $urandom;
            ry = $urandom;
            rs = 1'($urandom_range(0, 1));
            issue(rx, ry, rs, ref_mul(rx, ry, rs));
        end
        drain();
        chk_int("stall_cycles_seen", stall_cnt, 3);
        stall_start = -1;
        stall_end   = -1;

        // Reset with ops in flight
        for (int i = 0; i < 5; i++) begin
            rx = $urandom;
            ry = $urandom;
            issue(rx, ry, 1'b0, ref_mul(rx, ry, 1'b0));
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        reset    = 1'b1;
        sb.delete();
        @(posedge clk);
        #1;
        chk64("midreset_out_valid", {63'b0, out_valid}, 64'd0);
        chk64("midreset_out", out, 64'd0);
        chk64("midreset_in_ready", {63'b0, in_ready}, 64'd1);
        reset = 1'b0;
        idle(12);
        issue(32'd3, 32'd5, 1'b0, 64'd15);
        drain();

        // W=8 instance: 0x80 * 0x80 unsigned, then signed
        @(posedge clk);
        #1;
        t0 = cyc;
        in_valid8 = 1'b1; a8 = 8'h80; b8 = 8'h80; is_signed8 = 1'b0;
        @(posedge clk);
        #1;
        is_signed8 = 1'b1;
        @(posedge clk);
        #1;
        in_valid8 = 1'b0;
        for (int k = 0; k < 12 && cyc < t0 + LAT8 - 1; k++) @(negedge clk);
        chk64("w8_before_valid", {63'b0, out_valid8}, 64'd0);
        @(negedge clk);
        chk64("w8_valid_u", {63'b0, out_valid8}, 64'd1);
        chk64("w8_product_u", {48'b0, out8}, 64'h4000);
        @(negedge clk);
        chk64("w8_valid_s", {63'b0, out_valid8}, 64'd1);
        chk64("w8_product_s", {48'b0, out8}, 64'h4000);
        @(negedge clk);
        chk64("w8_after_valid", {63'b0, out_valid8}, 64'd0);
        chk64("w8_out_hold", {48'b0, out8}, 64'h4000);

        idle(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
